psum_drain: RTL and testbench

//   Controller and drain stage for the partial-sum accumulator. Counts accepted input beats, drives the

---
 rtl/psum_drain.sv | 157 +++++++++++++++
 tb/tb_psum_drain.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: controller and drain stage for the partial-sum accumulator.
//
// The block counts accepted input beats and drives the accumulator's enable and clear.
// After the last beat of a group it captures the completed sum. It requantizes the sum
// with an arithmetic right shift followed by saturation. Results are queued in a small
// FIFO that drains downstream with a valid/ready handshake.
//
// Optional feature (compile-time macro):
//   PSUM_DRAIN_RELU_EN  when defined, negative shifted sums are clamped to 0 before
//                       saturation. When undefined, signed results pass through.
//
// Ports:
//   clk         clock, all logic on posedge
//   reset       synchronous, active-high reset
//   in_valid    upstream beat available (data goes straight to the accumulator)
//   in_ready    block can accept a beat this cycle
//   acc_enable  accumulator enable, in_valid & in_ready
//   acc_clear   accumulator clear, reset | capture push
//   acc_in      accumulator running sum (signed, acc_bits)
//   out_valid   FIFO head valid
//   out_ready   downstream accepts head
//   out_data    FIFO head, requantized result (signed, out_bits)
module psum_drain #(
  parameter int unsigned acc_bits   = 16,
  parameter int unsigned out_bits   = 8,
  parameter int unsigned beats      = 9,
  parameter int unsigned shift      = 4,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                acc_enable,
  output logic                acc_clear,
  input  logic [acc_bits-1:0] acc_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [out_bits-1:0] out_data
);

  localparam int unsigned CntW = (beats > 1) ? $clog2(beats) : 1;
  localparam int unsigned PtrW = $clog2(fifo_depth);

  localparam logic [CntW-1:0]           LastBeat = CntW'(beats - 1);
  localparam logic [PtrW:0]             Depth    = (PtrW + 1)'(fifo_depth);
  localparam logic signed [acc_bits-1:0] QMax    = acc_bits'((2 ** (out_bits - 1)) - 1);
  localparam logic signed [acc_bits-1:0] QMin    = acc_bits'(-(2 ** (out_bits - 1)));

  typedef enum logic [0:0] {StAccum, StCapture} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [out_bits-1:0] mem_q [fifo_depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q, count_d;

  logic                       full;
  logic                       capture_push;
  logic                       pop;
  logic signed [acc_bits-1:0] shifted;
  logic signed [acc_bits-1:0] clamped;
  logic [out_bits-1:0]        quant;

  // Requantize: arithmetic shift (floor toward -inf), optional ReLU, then saturate.
  always_comb begin
    shifted = $signed(acc_in) >>> shift;
    clamped = shifted;
`ifdef PSUM_DRAIN_RELU_EN
    if (clamped < 0) begin
      clamped = '0;
    end
`endif
    if (clamped > QMax) begin
      clamped = QMax;
    end else if (clamped < QMin) begin
      clamped = QMin;
    end
    quant = clamped[out_bits-1:0];
  end

  // Fullness uses the current count only, so a same-cycle pop never frees a slot for a push.
  // This also keeps in_ready independent of out_ready.
  assign full      = (count_q == Depth);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // Gate the head so out_data reads 0 whenever the FIFO is empty (including after reset).
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    in_ready     = 1'b0;
    capture_push = 1'b0;
    unique case (state_q)
      StAccum: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d = '0;
            state_d    = StCapture;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StCapture: begin
        // While full, the accumulator is neither enabled nor cleared, so the sum is held.
        if (!full) begin
          capture_push = 1'b1;
          state_d      = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  assign acc_enable = in_valid & in_ready;
  assign acc_clear  = reset | capture_push;

  always_comb begin
    count_d = count_q;
    unique case ({capture_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAccum;
      beat_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      count_q    <= count_d;
      if (capture_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset; it is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (capture_push && !reset) begin
      mem_q[wr_ptr_q] <= quant;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: randomized scoreboard bench for psum_drain with a behavioural accumulator.
module tb_psum_drain;

  localparam int AccBits = 16;
  localparam int OutBits = 8;
  localparam int Beats   = 9;
  localparam int Shift   = 4;
  localparam int Depth   = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic                       acc_enable;
  logic                       acc_clear;
  logic signed [AccBits-1:0]  acc;
  logic signed [AccBits-1:0]  din;
  logic                       out_valid;
  logic                       out_ready;
  logic [OutBits-1:0]         out_data;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  psum_drain #(
    .acc_bits  (AccBits),
    .out_bits  (OutBits),
    .beats     (Beats),
    .shift     (Shift),
    .fifo_depth(Depth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_enable(acc_enable),
    .acc_clear (acc_clear),
    .acc_in    (acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Accumulator placed in front of the block, as in the real datapath.
  always_ff @(posedge clk) begin
    if (acc_clear) acc <= '0;
    else if (acc_enable) acc <= acc + din;
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference requantization: floor division by 2^Shift, then clamp.
  function automatic int quant_ref(input longint s);
    longint div;
    longint y;
    div = longint'(1) << Shift;
    y = s / div;
    if ((s % div) != 0 && s < 0) y = y - 1;
`ifdef PSUM_DRAIN_RELU_EN
    if (y < 0) y = 0;
`endif
    if (y > (2 ** (OutBits - 1)) - 1) y = (2 ** (OutBits - 1)) - 1;
    if (y < -(2 ** (OutBits - 1))) y = -(2 ** (OutBits - 1));
    return int'(y);
  endfunction

  // Transaction-level model: running sum, beats in group, pending capture, FIFO occupancy.
  longint sum = 0;
  int     nbeats = 0;
  bit     pending = 1'b0;
  int     occ = 0;

  always @(negedge clk) begin
    bit push;
    bit popm;
    if (reset) begin
      check("acc_clear_in_reset", acc_clear, 1);
      sum = 0;
      nbeats = 0;
      pending = 1'b0;
      occ = 0;
      exp_q.delete();
    end else begin
      push = pending && (occ < Depth);
      popm = (occ > 0) && out_ready;
      check("in_ready", in_ready, !pending);
      check("acc_enable", acc_enable, in_valid && !pending);
      check("acc_clear", acc_clear, push);
      check("out_valid", out_valid, occ > 0);
      check("acc_in", longint'(acc), sum);
      if (in_valid && !pending) begin
        sum += longint'(din);
        nbeats++;
        if (nbeats == Beats) begin
          nbeats = 0;
          pending = 1'b1;
          exp_q.push_back(quant_ref(sum));
        end
      end
      if (push) begin
        pending = 1'b0;
        sum = 0;
      end
      occ = occ + int'(push) - int'(popm);
    end
  end

  // Monitor: compares each accepted output against the scoreboard queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d, expected none at %0t",
                 $signed(out_data), $time);
      end else begin
        check("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input int val, input int n, input int gap_pct, input bit rnd);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 2000) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(99) >= gap_pct);
      din = rnd ? AccBits'($urandom_range(4000) - 2000) : AccBits'(val);
      if (rand_ready) out_ready = $urandom_range(1);
      @(negedge clk);
      if (in_valid && in_ready) got++;
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got %0d beats, expected %0d", got, n);
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check("drain_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    din = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_acc", acc, 0);

    send(16, 9, 0, 1'b0);     // 144 >>> 4 = 9
    send(1000, 9, 0, 1'b0);   // saturates to 127
    send(-100, 9, 0, 1'b0);   // -57 (0 with ReLU)
    wait_drain();

    // Back-pressure: four results fill the FIFO, fifth group waits in capture.
    out_ready = 1'b0;
    repeat (5) send(16, 9, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    wait_drain();

    // Reset in the middle of a group discards the partial sum.
    send(16, 5, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(32, 9, 0, 1'b0);     // 288 >>> 4 = 18
    wait_drain();

    send(8, 9, 50, 1'b0);     // gaps on in_valid, result 4
    wait_drain();

    rand_ready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      send(0, 9, $urandom_range(60), 1'b1);
    end
    rand_ready = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
